// File: rtl/mem_a_skew_db.sv
// Double-buffered operand-A buffer for the systolic array: one bank loads row by row
// while the other streams out, with lane r delayed r cycles onto the array diagonal.
module mem_a_skew_db #(
    parameter int BITS_AB = 8,
    parameter int ROWS    = 8,
    parameter int COLS    = 8
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                wr_en,
    input  logic [$clog2(ROWS)-1:0]             wr_row,
    input  logic signed [COLS-1:0][BITS_AB-1:0] Ain,
    input  logic                                load_done,
    input  logic                                start,
    input  logic                                en,
    output logic signed [ROWS-1:0][BITS_AB-1:0] Aout,
    output logic [ROWS-1:0]                     Aout_vld,
    output logic                                load_rdy,
    output logic                                stream_rdy,
    output logic                                busy,
    output logic                                done
);
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(ROWS + COLS);
    localparam logic [CW-1:0] LAST = CW'(ROWS + COLS - 2);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [1:0]    full;
    logic          wb, rb;
    logic          row_ok, last_step;

    logic [COLS-1:0][BITS_AB-1:0]        mem [2][ROWS];
    logic signed [ROWS-1:0][BITS_AB-1:0] skew_data;
    logic [ROWS-1:0]                     skew_vld;

    // Widened compare so non-power-of-two ROWS can reject out-of-range rows.
    assign row_ok     = {1'b0, wr_row} < (RW + 1)'(ROWS);
    assign last_step  = (state == STREAM) && en && (cnt == LAST);
    assign load_rdy   = !full[wb];
    assign stream_rdy = full[rb];
    assign busy       = (state == STREAM);

    always_ff @(posedge clk) begin
        if (wr_en && !full[wb] && row_ok)
            mem[wb][wr_row] <= Ain;
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (start && full[rb]) begin
                    state_nxt = STREAM;
                    cnt_nxt   = '0;
                end
            end
            STREAM: begin
                if (en) begin
                    if (cnt == LAST)
                        state_nxt = IDLE;
                    else
                        cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Load and stream pointers always refer to different banks while both are active.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full <= 2'b00;
            wb   <= 1'b0;
            rb   <= 1'b0;
        end else begin
            if (load_done && !full[wb]) begin
                full[wb] <= 1'b1;
                wb       <= ~wb;
            end
            if (last_step) begin
                full[rb] <= 1'b0;
                rb       <= ~rb;
            end
        end
    end

    // Lane r shows column t-r when it lies inside the row, found by matching t == r+c.
    always_comb begin
        skew_data = '0;
        skew_vld  = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (cnt == CW'(r + c)) begin
                    skew_data[r] = mem[rb][r][c];
                    skew_vld[r]  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Aout     <= '0;
            Aout_vld <= '0;
            done     <= 1'b0;
        end else if (en) begin
            if (state == STREAM) begin
                Aout     <= skew_data;
                Aout_vld <= skew_vld;
                done     <= (cnt == LAST);
            end else begin
                Aout     <= '0;
                Aout_vld <= '0;
                done     <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mem_a_skew_db.sv
// Scoreboard bench for mem_a_skew_db: a 4x4 main instance plus two tiny instances
// covering the single-column corner and out-of-range row writes.
`timescale 1ns/1ps
module tb_mem_a_skew_db;
    localparam int W    = 8;
    localparam int R    = 4;
    localparam int C    = 4;
    localparam int LAST = R + C - 2;

    typedef struct {
        logic [R-1:0][W-1:0] aout;
        logic [R-1:0]        vld;
        logic                done;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    logic                wr_en, load_done, start, en;
    logic [1:0]          wr_row;
    logic [R-1:0][W-1:0] ain;
    logic [R-1:0][W-1:0] aout;
    logic [R-1:0]        aout_vld;
    logic                load_rdy, stream_rdy, busy, done;

    logic             x_wr_en, x_load_done, x_start, x_en;
    logic [0:0]       b_row;
    logic [0:0][W-1:0] b_ain;
    logic [1:0][W-1:0] b_aout;
    logic [1:0]       b_vld;
    logic             b_lrdy, b_srdy, b_busy, b_done;
    logic [1:0]       c_row;
    logic [0:0][W-1:0] c_ain;
    logic [2:0][W-1:0] c_aout;
    logic [2:0]       c_vld;
    logic             c_lrdy, c_srdy, c_busy, c_done;

    int   vectors    = 0;
    int   miscompares = 0;
    exp_t sb[$];
    exp_t cur;
    logic [W-1:0] mbank [2][R][C];
    logic [1:0]   mfull;
    logic         mwb, mrb, mbusy;
    int           mt;

    always #5 clk = ~clk;

    mem_a_skew_db #(.BITS_AB(W), .ROWS(R), .COLS(C)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_row(wr_row), .Ain(ain),
        .load_done(load_done), .start(start), .en(en), .Aout(aout), .Aout_vld(aout_vld),
        .load_rdy(load_rdy), .stream_rdy(stream_rdy), .busy(busy), .done(done)
    );

    mem_a_skew_db #(.BITS_AB(W), .ROWS(2), .COLS(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .wr_en(x_wr_en), .wr_row(b_row), .Ain(b_ain),
        .load_done(x_load_done), .start(x_start), .en(x_en), .Aout(b_aout), .Aout_vld(b_vld),
        .load_rdy(b_lrdy), .stream_rdy(b_srdy), .busy(b_busy), .done(b_done)
    );

    mem_a_skew_db #(.BITS_AB(W), .ROWS(3), .COLS(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .wr_en(x_wr_en), .wr_row(c_row), .Ain(c_ain),
        .load_done(x_load_done), .start(x_start), .en(x_en), .Aout(c_aout), .Aout_vld(c_vld),
        .load_rdy(c_lrdy), .stream_rdy(c_srdy), .busy(c_busy), .done(c_done)
    );

    task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        checkVal($sformatf("%s.aout", tag), aout, cur.aout);
        checkVal($sformatf("%s.vld", tag), aout_vld, cur.vld);
        checkVal($sformatf("%s.done", tag), done, cur.done);
        checkVal($sformatf("%s.busy", tag), busy, mbusy);
        checkVal($sformatf("%s.load_rdy", tag), load_rdy, !mfull[mwb]);
        checkVal($sformatf("%s.stream_rdy", tag), stream_rdy, mfull[mrb]);
    endtask

    function automatic logic [R-1:0][W-1:0] rowA(input int r, input int off);
        logic [R-1:0][W-1:0] v;
        for (int c = 0; c < C; c++) v[c] = W'(16 * r + c + off);
        return v;
    endfunction

    task automatic clearModel();
        mfull    = 2'b00;
        mwb      = 1'b0;
        mrb      = 1'b0;
        mbusy    = 1'b0;
        mt       = 0;
        sb.delete();
        cur.aout = '0;
        cur.vld  = '0;
        cur.done = 1'b0;
    endtask

    task automatic pushStream();
        exp_t e;
        for (int t = 0; t <= LAST; t++) begin
            e.aout = '0;
            e.vld  = '0;
            for (int r = 0; r < R; r++)
                for (int c = 0; c < C; c++)
                    if (t == r + c) begin
                        e.aout[r] = mbank[mrb][r][c];
                        e.vld[r]  = 1'b1;
                    end
            e.done = (t == LAST);
            sb.push_back(e);
        end
    endtask

    task automatic applyStimulus(input string tag, input logic w, input logic [1:0] row,
                                 input logic [R-1:0][W-1:0] data, input logic ld,
                                 input logic st, input logic e);
        wr_en = w; wr_row = row; ain = data; load_done = ld; start = st; en = e;
        @(posedge clk);
        if (w && !mfull[mwb])
            for (int c = 0; c < C; c++) mbank[mwb][row][c] = data[c];
        if (ld && !mfull[mwb]) begin
            mfull[mwb] = 1'b1;
            mwb        = ~mwb;
        end
        if (mbusy) begin
            if (e) begin
                cur = sb.pop_front();
                if (mt == LAST) begin
                    mfull[mrb] = 1'b0;
                    mrb        = ~mrb;
                    mbusy      = 1'b0;
                end
                mt++;
            end
        end else begin
            if (e) begin
                cur.aout = '0;
                cur.vld  = '0;
                cur.done = 1'b0;
            end
            if (st && mfull[mrb]) begin
                mbusy = 1'b1;
                mt    = 0;
                pushStream();
            end
        end
        #1;
        wr_en = 1'b0; load_done = 1'b0; start = 1'b0;
        checkOutput(tag);
    endtask

    task automatic loadBank(input string tag, input int off);
        for (int r = 0; r < R; r++) applyStimulus(tag, 1'b1, 2'(r), rowA(r, off), 1'b0, 1'b0, 1'b1);
    endtask

    task automatic smallStep(input logic w, input logic brow, input int bval,
                             input logic [1:0] crow, input int cval, input logic ld, input logic st);
        x_wr_en = w; b_row = brow; b_ain = W'(bval); c_row = crow; c_ain = W'(cval);
        x_load_done = ld; x_start = st; x_en = 1'b1;
        @(posedge clk);
        #1;
        x_wr_en = 1'b0; x_load_done = 1'b0; x_start = 1'b0;
    endtask

    initial begin
        wr_en = 0; wr_row = 0; ain = '0; load_done = 0; start = 0; en = 1;
        x_wr_en = 0; x_load_done = 0; x_start = 0; x_en = 1;
        b_row = 0; b_ain = '0; c_row = 0; c_ain = '0;
        clearModel();
        #12;
        checkOutput("reset");
        @(negedge clk) rst_n = 1'b1;

        $display("[TB] basic stream");
        loadBank("basic.load", 0);
        applyStimulus("basic.ld", 0, 0, '0, 1, 0, 1);
        applyStimulus("basic.start", 0, 0, '0, 0, 1, 1);
        for (int k = 0; k < R + C; k++) begin
            applyStimulus("basic.run", 0, 0, '0, 0, 0, 1);
            if (k == 0) begin
                checkVal("basic.lane0_t0", aout[0], 8'd0);
                checkVal("basic.vld_t0", aout_vld, 4'b0001);
            end
            if (k == 6) begin
                checkVal("basic.lane3_last", aout[3], 8'd51);
                checkVal("basic.vld_last", aout_vld, 4'b1000);
                checkVal("basic.done_last", done, 1'b1);
            end
            if (k == 7) checkVal("basic.busy_after", busy, 1'b0);
        end

        $display("[TB] ping-pong");
        loadBank("pp.loadA", 0);
        applyStimulus("pp.ldA", 0, 0, '0, 1, 0, 1);
        applyStimulus("pp.startA", 0, 0, '0, 0, 1, 1);
        loadBank("pp.loadB", 100);
        checkVal("pp.load_rdy_before", load_rdy, 1'b1);
        applyStimulus("pp.ldB", 0, 0, '0, 1, 0, 1);
        checkVal("pp.load_rdy_full", load_rdy, 1'b0);
        repeat (2) applyStimulus("pp.runA", 0, 0, '0, 0, 0, 1);
        checkVal("pp.doneA", done, 1'b1);
        applyStimulus("pp.startB", 0, 0, '0, 0, 1, 1);
        checkVal("pp.busyB", busy, 1'b1);
        for (int k = 0; k < R + C - 1; k++) begin
            applyStimulus("pp.runB", 0, 0, '0, 0, 0, 1);
            if (k == 3) checkVal("pp.laneB0_t3", aout[0], 8'd103);
        end

        $display("[TB] overflow");
        loadBank("ovf.loadA", 0);
        applyStimulus("ovf.ldA", 0, 0, '0, 1, 0, 1);
        loadBank("ovf.loadB", 100);
        applyStimulus("ovf.ldB", 0, 0, '0, 1, 0, 1);
        applyStimulus("ovf.wr7f", 1, 0, {R{8'h7F}}, 0, 0, 1);
        applyStimulus("ovf.ld7f", 0, 0, '0, 1, 0, 1);
        applyStimulus("ovf.start", 0, 0, '0, 0, 1, 1);
        for (int k = 0; k < R + C - 1; k++) begin
            applyStimulus("ovf.run", 0, 0, '0, 0, 0, 1);
            if (k == 0) checkVal("ovf.lane0_t0", aout[0], 8'd0);
            if (k == 3) checkVal("ovf.lane3_t3", aout[3], 8'd48);
        end

        $display("[TB] stall");
        applyStimulus("stall.start", 0, 0, '0, 0, 1, 1);
        repeat (3) applyStimulus("stall.pre", 0, 0, '0, 0, 0, 1);
        repeat (3) applyStimulus("stall.hold", 0, 0, '0, 0, 0, 0);
        checkVal("stall.held_lane0", aout[0], 8'd102);
        applyStimulus("stall.resume", 0, 0, '0, 0, 0, 1);
        checkVal("stall.resume_lane0", aout[0], 8'd103);
        checkVal("stall.resume_vld", aout_vld, 4'b1111);
        repeat (3) applyStimulus("stall.post", 0, 0, '0, 0, 0, 1);
        checkVal("stall.done", done, 1'b1);
        applyStimulus("stall.tail", 0, 0, '0, 0, 0, 1);

        $display("[TB] start with empty bank");
        applyStimulus("nostart", 0, 0, '0, 0, 1, 1);
        checkVal("nostart.busy", busy, 1'b0);

        $display("[TB] async reset mid-stream");
        loadBank("rst.load", 0);
        applyStimulus("rst.ld", 0, 0, '0, 1, 0, 1);
        applyStimulus("rst.start", 0, 0, '0, 0, 1, 1);
        repeat (3) applyStimulus("rst.run", 0, 0, '0, 0, 0, 1);
        #2 rst_n = 1'b0;
        #1;
        clearModel();
        checkOutput("rst.async");
        #1 rst_n = 1'b1;
        applyStimulus("rst.ignored_start", 0, 0, '0, 0, 1, 1);
        loadBank("rst.reload", 50);
        applyStimulus("rst.reld", 0, 0, '0, 1, 0, 1);
        applyStimulus("rst.restart", 0, 0, '0, 0, 1, 1);
        repeat (R + C) applyStimulus("rst.rerun", 0, 0, '0, 0, 0, 1);

        $display("[TB] small instances");
        smallStep(0, 0, 0, 0, 0, 0, 1);
        checkVal("small.b_nostart", b_busy, 1'b0);
        checkVal("small.c_nostart", c_busy, 1'b0);
        smallStep(1, 0, 5, 0, 10, 0, 0);
        smallStep(1, 1, 9, 1, 20, 0, 0);
        smallStep(1, 1, 9, 2, 30, 0, 0);
        smallStep(1, 1, 9, 3, 99, 0, 0);
        smallStep(0, 0, 0, 0, 0, 1, 0);
        checkVal("small.c_srdy", c_srdy, 1'b1);
        checkVal("small.b_lrdy", b_lrdy, 1'b1);
        smallStep(0, 0, 0, 0, 0, 0, 1);
        checkVal("small.b_busy", b_busy, 1'b1);
        smallStep(0, 0, 0, 0, 0, 0, 0);
        checkVal("small.b_t0", {b_vld, b_done, b_aout}, {2'b01, 1'b0, 16'h0005});
        checkVal("small.c_t0", {c_vld, c_done, c_aout}, {3'b001, 1'b0, 24'h00000A});
        smallStep(0, 0, 0, 0, 0, 0, 0);
        checkVal("small.b_t1", {b_vld, b_done, b_busy, b_aout}, {2'b10, 1'b1, 1'b0, 16'h0900});
        checkVal("small.c_t1", {c_vld, c_done, c_aout}, {3'b010, 1'b0, 24'h001400});
        smallStep(0, 0, 0, 0, 0, 0, 0);
        checkVal("small.b_after", {b_vld, b_done, b_aout}, {2'b00, 1'b0, 16'h0000});
        checkVal("small.c_t2", {c_vld, c_done, c_busy, c_aout}, {3'b100, 1'b1, 1'b0, 24'h1E0000});

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/mem_a_skew_db.md
# mem_a_skew_db

Double-buffered, skewing operand-A buffer for the systolic matrix-multiply array. One bank is loaded a row at a time while the other streams out. Row r is delayed r cycles, so each element reaches the array diagonal on the correct cycle. It generalises the single-bank delay-FIFO A memory with these additions:
- independent ROWS/COLS;
- ping-pong banks;
- a streaming sequencer with stall;
- per-row valid flags and a completion pulse.

## Interface
- BITS_AB, 8, signed element width
- ROWS, 8, array rows = number of output lanes (≥2)
- COLS, 8, elements per row = reduction length K (≥1)

- clk  in  1  clock, all logic rising-edge
- rst_n  in  1  asynchronous active-low reset
- wr_en  in  1  write Ain into row wr_row of the load bank
- wr_row  in  $clog2(ROWS)  target row; values ≥ROWS are ignored
- Ain  in  COLS×BITS_AB signed  one full row, Ain[c] = column c
- load_done  in  1  marks the load bank complete
- start  in  1  request streaming of the full bank
- en  in  1  stream advance; 0 stalls the sequencer and holds outputs
- Aout  out  ROWS×BITS_AB signed  skewed element per lane
- Aout_vld  out  ROWS  per-lane valid
- load_rdy  out  1  load bank writable (not full)
- stream_rdy  out  1  the stream bank is full
- busy  out  1  sequencer not IDLE
- done  out  1  one-cycle pulse with the last valid output

## Operation
- Storage: two banks, each holding ROWS×COLS words, plus `full[1:0]`, the load pointer `wb` and the stream pointer `rb`. Memory contents are not reset.
- Write: `wr_en && !full[wb]` writes `bank[wb][wr_row][*] = Ain[*]`. Writes to a full bank are dropped.
- `load_done && !full[wb]`: sets `full[wb]` and toggles `wb`. `load_done` when `full[wb]` is ignored.
  - `wr_en` and `load_done` in the same cycle: the write lands, then the bank is marked full.
- Outputs: `load_rdy = !full[wb]`; `stream_rdy = full[rb]`.
- FSM:
  - IDLE → STREAM on `start && full[rb]`; clears the counter to t=0. `start` is ignored outside IDLE or when the bank is not full.
  - STREAM: t increments on each cycle with `en=1`. It holds when `en=0`.
  - At t = ROWS+COLS−2 with `en=1`: the FSM goes to IDLE, clears `full[rb]` and toggles `rb`.
- Skew rule at count t, lane r:
  - If r ≤ t < r+COLS: `Aout[r] = bank[rb][r][t−r]`, `Aout_vld[r] = 1`.
  - Otherwise: `Aout[r] = 0`, `Aout_vld[r] = 0`.
- Concurrency: load into bank `wb` proceeds while bank `rb` streams. Releasing `full[rb]` and setting `full[wb]` in the same cycle is legal and independent.
- After reset: `wb = rb = 0`, `full = 0`, FSM in IDLE.

## Timing
- Reset values: Aout all 0, Aout_vld 0, busy 0, done 0, load_rdy 1, stream_rdy 0.
- Reset mid-stream or mid-load aborts immediately. Both banks become empty and all outputs return to their reset values.
- Outputs are registered, with 1-cycle latency from count t to Aout.
- `start` sampled at edge E0 → `busy` = 1 after E0. Aout for t=0 appears after E1.
- A stream lasts ROWS+COLS−1 `en`-qualified cycles.
- `done` and the last `Aout_vld[ROWS−1]` occur in the same cycle. `busy` falls in that same cycle; outputs are registered from the final count.
- The cycle after the last output returns Aout = 0 and vld = 0, unless `en = 0`.
- `en=0` during STREAM: Aout, Aout_vld and done all hold their previous values, so a held done stays high.
- Back-to-back streaming:
  - `start` is accepted in the IDLE cycle after `done`, so one bubble cycle separates tiles.
  - `stream_rdy` reflects the swapped bank in that cycle.
- A `wr_en` the cycle after `load_done` targets the other bank, if that bank is empty.

## Test plan
- **Basic stream.** Setup: ROWS=COLS=4, A[r][c]=16r+c, load rows 0–3, load_done, start, en=1. Required:
  - lane0 emits 0,1,2,3 at t=0..3;
  - lane3 emits 48,49,50,51 at t=3..6;
  - vld follows the diagonal;
  - done coincides with t=6 (value 51), then busy=0.
- **Ping-pong.** Load bank0 with A, load_done, start. While it streams, load bank1 with B=A+100 and load_done. Required:
  - load_rdy goes 0 only after the second load_done;
  - a second start, given one cycle after done, streams B with identical skew.
- **Overflow protection.** Fill both banks: load_rdy=0. A further wr_en with Ain=all 0x7F and load_done are ignored, and a later stream of bank0 returns the original A.
- **Stall.** Drop en for 3 cycles at t=2. Required:
  - Aout and Aout_vld frozen for those 3 cycles;
  - the sequence resumes with t=3 data;
  - total stream 7+3 cycles.
- **Boundaries.** ROWS=2, COLS=1: one element per lane, lane1 one cycle after lane0, done with lane1. Also:
  - start with stream_rdy=0 leaves busy=0;
  - wr_row=ROWS (out of range) is ignored.
- **Async reset mid-stream at t=3.** Required:
  - all outputs 0 asynchronously;
  - load_rdy=1, stream_rdy=0;
  - the next start is ignored until a fresh load + load_done.
